// File: rtl/mem_burst_master.sv
// Burst initiator for the single-port valid/ready memory interface.
// Issues one memory transaction per beat with an incrementing data pattern and checks read data.
module mem_burst_master #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  input  logic [WIDTH-1:0]      cmd_seed_i,
  input  logic                  cmd_check_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  output logic                  mem_wr_rd_o,
  output logic                  mem_valid_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   mismatch_cnt_o
);

  localparam int unsigned LW = ADDR_WIDTH + 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_nxt;
  logic                  accept, beat_ok, tmo_hit, last_beat;

  logic                  cmd_ready_q, mem_valid_q, done_q, rd_valid_q, err_q;
  logic                  wr_q, check_q;
  logic [LW-1:0]         len_q, idx_q, mism_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q, rd_data_q;
  logic [TW-1:0]         tmo_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    beat_ok   = 1'b0;
    tmo_hit   = 1'b0;
    last_beat = ((idx_q + LW'(1)) == len_q);
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          accept    = 1'b1;
          state_nxt = (cmd_len_i == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (mem_ready_i) begin
          beat_ok   = 1'b1;
          state_nxt = last_beat ? ST_DONE : ST_ISSUE;
        end else if (tmo_q == TW'(TIMEOUT)) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath; state-decoded outputs are registered from the next state
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cmd_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      wr_q        <= 1'b0;
      check_q     <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      mism_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      tmo_q       <= '0;
    end else begin
      cmd_ready_q <= (state_nxt == ST_IDLE);
      mem_valid_q <= (state_nxt == ST_ISSUE);
      done_q      <= (state_nxt == ST_DONE);
      rd_valid_q  <= 1'b0;

      if (accept) begin
        wr_q    <= cmd_wr_i;
        check_q <= cmd_check_i;
        len_q   <= cmd_len_i;
        addr_q  <= cmd_addr_i;
        wdata_q <= cmd_seed_i;
        idx_q   <= '0;
        err_q   <= 1'b0;
        mism_q  <= '0;
      end

      if (state_q == ST_ISSUE)
        tmo_q <= '0;
      else if ((state_q == ST_WAIT) && !mem_ready_i && !tmo_hit)
        tmo_q <= tmo_q + TW'(1);

      // wdata_q always equals seed+index, so it doubles as the read reference
      if (beat_ok) begin
        idx_q   <= idx_q + LW'(1);
        addr_q  <= addr_q + ADDR_WIDTH'(1);
        wdata_q <= wdata_q + WIDTH'(1);
        if (!wr_q) begin
          rd_data_q  <= mem_rdata_i;
          rd_valid_q <= 1'b1;
          if (check_q && (mem_rdata_i != wdata_q) && (mism_q != {LW{1'b1}}))
            mism_q <= mism_q + LW'(1);
        end
      end

      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign mem_wr_rd_o    = wr_q;
  assign mem_valid_o    = mem_valid_q;
  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign mismatch_cnt_o = mism_q;

endmodule
